input_port_fifo: RTL and testbench
==================================

Name: input_port_fifo

Overview:
- Buffered input port that sits directly upstream of the microprocessor's `i_pins` input.
- An external producer pushes 4-bit nibbles through a valid/ready handshake into a small FIFO.
- The FIFO head drives `i_pins`.
- The block watches the microprocessor's exported `ir`. When it decodes an instruction that reads `i_pins`, it pops the head at the end of that cycle, so every executed i_pins read consumes exactly one nibble.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- IR_MATCH, 8'b10_000_100, `ir` pattern identifying an i_pins-read instruction.
- IR_MASK, 8'b11_000_111, bits of `ir` compared against IR_MATCH; the pattern is move, any destination, source = i_pins.
- EMPTY_VALUE, 4'h0, value driven on `i_pins` while the FIFO is empty.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- sync_reset  input  1  synchronous active-high reset.
- in_data  input  4  producer nibble.
- in_valid  input  1  producer offers `in_data`.
- in_ready  output  1  FIFO can accept a nibble this cycle.
- ir  input  8  microprocessor instruction register.
- i_pins  output  4  nibble presented to the microprocessor.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- fifo_count  output  $clog2(DEPTH)+1  number of entries held.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high.
  - `sync_reset` sampled high at a posedge clears the write pointer, read pointer and count.
  - Reset values: empty=1, full=0, fifo_count=0, in_ready=1 (low while `sync_reset` is high), i_pins=EMPTY_VALUE. Storage contents are don't-care.
  - Reset mid-stream discards all entries. Any push or pop in the reset cycle is ignored.
- Push:
  - push = in_valid & in_ready.
  - in_ready = ~full & ~sync_reset. It depends only on registered state plus reset, never on pop, so there is no combinational path from `ir` to `in_ready`.
  - On push, `in_data` is written at the write pointer and the write pointer increments, wrapping DEPTH-1 -> 0.
- Read detection:
  - rd_hit = ((ir & IR_MASK) == (IR_MATCH & IR_MASK)). This is purely combinational.
  - The microprocessor loads `ir` on posedge and executes in that same cycle. The destination register captures `i_pins` at the following posedge.
- Output:
  - i_pins = empty ? EMPTY_VALUE : storage[rd_ptr], combinational from registered pointers.
  - It is stable for the whole cycle in which rd_hit is asserted.
- Pop:
  - pop = rd_hit & ~empty & ~sync_reset.
  - On pop, the read pointer increments with wrap, effective at the same posedge where the CPU captures the nibble.
  - Back-to-back read instructions on consecutive cycles pop consecutive entries.
- Count update:
  - push only: +1. pop only: -1. Both: unchanged. Neither: unchanged.
  - The pointer-equals case is resolved by the count; the pointers never disambiguate full from empty.
- Boundaries:
  - Push and pop in the same cycle when full: cannot occur, because in_ready=0.
  - rd_hit while empty: no pop, pointers unchanged. The CPU reads EMPTY_VALUE. A simultaneous push is accepted, and that nibble appears on `i_pins` the next cycle.
  - Push into the last slot: full asserts the next cycle and in_ready drops.
  - Wrap-around: data order is preserved across any number of pointer wraps.
- Latency: a nibble pushed at posedge N is visible on `i_pins` from N+1 if the FIFO was empty.
- All outputs are registered-state derived except in_ready's reset gating and i_pins' mux.

Optional Feature:
- Macro: INPUT_PORT_FIFO_UNDERFLOW_STICKY_EN.
- Defined:
  - Adds output port `underflow` (1 bit, reset 0).
  - It sets at the posedge after any cycle with rd_hit & empty & ~sync_reset.
  - It stays set until `sync_reset`.
- Not defined: port absent; read-while-empty is silently ignored.

Test Plan:
- Reset: hold `sync_reset` 2 cycles with in_valid=1, in_data=4'hA. Required: empty=1, fifo_count=0, i_pins=4'h0, no entry stored after release.
- Ordered delivery: push 4'h3, 4'h7, 4'hC, then present ir=8'b10_010_100 for 3 consecutive cycles. Required: i_pins reads 3, 7, C on those cycles, then fifo_count=0 and i_pins=0.
- Full: push 8 nibbles 4'h1..4'h8 with no reads. Required: full=1, in_ready=0, fifo_count=8, and a 9th offer of 4'hF is not accepted. Then read all 8 and confirm the sequence 1..8.
- Simultaneous push/pop: with count=3, push 4'h5 while ir matches. Required: count stays 3, head advances one entry, 4'h5 is appended at the tail.
- Wrap-around: 20 interleaved push/pop pairs of an incrementing nibble. Required: output sequence equals input sequence mod 16 and count never exceeds 8.
- Non-matching / empty read: ir=8'b10_010_011 with data present gives no pop. ir matching while empty gives i_pins=0 and count stays 0. With the macro defined, underflow=1 the next cycle and stays set until reset.

Source files
------------

// File: rtl/input_port_fifo_if.sv
// Producer-side valid/ready handshake for the input port FIFO.
// master: the nibble producer. slave: the FIFO.
interface input_port_fifo_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/input_port_fifo.sv
// Buffered input port in front of the CPU's i_pins.
// A producer pushes nibbles into a small FIFO. The FIFO head drives i_pins.
// Each executed i_pins-read instruction, decoded from ir, pops exactly one entry.
// Optional: define INPUT_PORT_FIFO_UNDERFLOW_STICKY_EN to add a sticky
// 'underflow' flag. It sets when a read is decoded while the FIFO is empty.
module input_port_fifo #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [7:0]  IR_MATCH    = 8'b10_000_100,
  parameter logic [7:0]  IR_MASK     = 8'b11_000_111,
  parameter logic [3:0]  EMPTY_VALUE = 4'h0,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic                clk,
  input  logic                sync_reset,
  input_port_fifo_if.slave    prod,
  input  logic [7:0]          ir,
  output logic [3:0]          i_pins,
  output logic                empty,
  output logic                full,
`ifdef INPUT_PORT_FIFO_UNDERFLOW_STICKY_EN
  output logic                underflow,
`endif
  output logic [CW-1:0]       fifo_count
);

  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          rd_hit, push, pop;

  // Status flags come from the count. The pointers alone cannot tell full from empty.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    fifo_count = count_q;
  end

  // Handshake and read decode. in_ready deliberately ignores pop, so ir cannot reach it.
  always_comb begin
    prod.in_ready = ~full & ~sync_reset;
    rd_hit        = ((ir & IR_MASK) == (IR_MATCH & IR_MASK));
    push          = prod.in_valid & prod.in_ready;
    pop           = rd_hit & ~empty & ~sync_reset;
    i_pins        = empty ? EMPTY_VALUE : mem_q[rd_ptr_q];
  end

  // Next-state computation for the storage, pointers and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (sync_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = prod.in_data;
        wr_ptr_d        = AW'(wr_ptr_q + 1'b1);
      end
      if (pop) rd_ptr_d = AW'(rd_ptr_q + 1'b1);
      case ({push, pop})
        2'b10:   count_d = CW'(count_q + 1'b1);
        2'b01:   count_d = CW'(count_q - 1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers. The reset is synchronous.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Storage has no reset. Its contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef INPUT_PORT_FIFO_UNDERFLOW_STICKY_EN
  logic underflow_q, underflow_d;

  // Sticky flag for a read decoded while empty. Only reset clears it.
  always_comb begin
    underflow_d = underflow_q;
    if (sync_reset)            underflow_d = 1'b0;
    else if (rd_hit && empty)  underflow_d = 1'b1;
    underflow = underflow_q;
  end

  // Underflow register.
  always_ff @(posedge clk) begin
    underflow_q <= underflow_d;
  end
`endif

endmodule

// File: tb/tb_input_port_fifo.sv
// Self-checking bench for input_port_fifo.
// A table of directed vectors, hand-written multi-cycle sequences, and random
// traffic. Every cycle is checked against a queue-based reference model.
module tb_input_port_fifo;
  localparam int DEPTH = 8;
  localparam logic [7:0] RD  = 8'b10_010_100;
  localparam logic [7:0] NM  = 8'b10_010_011;
  localparam logic [7:0] NOP = 8'h00;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [7:0] ir;
  logic [3:0] i_pins;
  logic       empty, full;
  logic [3:0] fifo_count;
`ifdef INPUT_PORT_FIFO_UNDERFLOW_STICKY_EN
  logic       underflow;
`endif

  input_port_fifo_if pif();

  input_port_fifo dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .prod       (pif),
    .ir         (ir),
    .i_pins     (i_pins),
    .empty      (empty),
    .full       (full),
`ifdef INPUT_PORT_FIFO_UNDERFLOW_STICKY_EN
    .underflow  (underflow),
`endif
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: FIFO contents as a queue, plus the sticky underflow flag
  int q[$];
  bit uf_m;
  bit cur_r, cur_v;
  logic [3:0] cur_d;
  logic [7:0] cur_ir;

  typedef struct {
    bit         r;
    bit         v;
    logic [3:0] d;
    logic [7:0] ir;
    logic [3:0] e_ipins;
    bit         e_rdy;
    logic [3:0] e_cnt;
    bit         e_empty;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply the inputs for one cycle. At the falling edge, compare the outputs with the model.
  task automatic drive(input bit r, input bit v, input logic [3:0] d, input logic [7:0] i);
    sync_reset   = r;
    pif.in_valid = v;
    pif.in_data  = d;
    ir           = i;
    cur_r = r; cur_v = v; cur_d = d; cur_ir = i;
    @(negedge clk);
    chk("in_ready", pif.in_ready, (q.size() < DEPTH) && !r);
    chk("i_pins",   i_pins, q.size() > 0 ? q[0] : 0);
    chk("empty",    empty, q.size() == 0);
    chk("full",     full, q.size() == DEPTH);
    chk("count",    fifo_count, q.size());
`ifdef INPUT_PORT_FIFO_UNDERFLOW_STICKY_EN
    chk("underflow", underflow, uf_m);
`endif
  endtask

  // Clock edge, then update the model from the rules.
  task automatic tick();
    bit hit;
    int sz;
    @(posedge clk);
    #1;
    hit = ((cur_ir & 8'hC7) == 8'h84);
    sz  = q.size();
    if (cur_r) begin
      q.delete();
      uf_m = 0;
    end else begin
      if (hit && sz == 0) uf_m = 1;
      if (hit && sz > 0) void'(q.pop_front());
      if (cur_v && sz < DEPTH) q.push_back(int'(cur_d));
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [3:0] d, input logic [7:0] i);
    drive(r, v, d, i);
    tick();
  endtask

  task automatic do_reset();
    cyc(1, 0, 4'h0, NOP);
  endtask

  initial begin
    // Reset, ordered delivery, non-matching read, empty read with push.
    tbl[0]  = '{1, 1, 4'hA, NOP, 4'h0, 0, 4'd0, 1};
    tbl[1]  = '{1, 1, 4'hA, NOP, 4'h0, 0, 4'd0, 1};
    tbl[2]  = '{0, 0, 4'h0, NOP, 4'h0, 1, 4'd0, 1};
    tbl[3]  = '{0, 1, 4'h3, NOP, 4'h0, 1, 4'd0, 1};
    tbl[4]  = '{0, 1, 4'h7, NOP, 4'h3, 1, 4'd1, 0};
    tbl[5]  = '{0, 1, 4'hC, NOP, 4'h3, 1, 4'd2, 0};
    tbl[6]  = '{0, 0, 4'h0, RD,  4'h3, 1, 4'd3, 0};
    tbl[7]  = '{0, 0, 4'h0, RD,  4'h7, 1, 4'd2, 0};
    tbl[8]  = '{0, 0, 4'h0, RD,  4'hC, 1, 4'd1, 0};
    tbl[9]  = '{0, 0, 4'h0, NOP, 4'h0, 1, 4'd0, 1};
    tbl[10] = '{0, 0, 4'h0, RD,  4'h0, 1, 4'd0, 1};
    tbl[11] = '{0, 1, 4'h9, RD,  4'h0, 1, 4'd0, 1};
    tbl[12] = '{0, 0, 4'h0, NM,  4'h9, 1, 4'd1, 0};
    tbl[13] = '{0, 0, 4'h0, NOP, 4'h9, 1, 4'd1, 0};
    tbl[14] = '{0, 0, 4'h0, RD,  4'h9, 1, 4'd1, 0};
    tbl[15] = '{0, 0, 4'h0, NOP, 4'h0, 1, 4'd0, 1};

    pif.in_valid = 0;
    pif.in_data  = 0;
    ir           = NOP;
    uf_m         = 0;
    // Initial reset: outputs are unknown before it, so nothing is checked here.
    sync_reset = 1;
    cur_r = 1; cur_v = 0; cur_d = 0; cur_ir = NOP;
    tick();

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].r, tbl[k].v, tbl[k].d, tbl[k].ir);
      chk($sformatf("vec%0d_ipins", k), i_pins,           tbl[k].e_ipins);
      chk($sformatf("vec%0d_rdy", k),   pif.in_ready,     tbl[k].e_rdy);
      chk($sformatf("vec%0d_cnt", k),   fifo_count,       tbl[k].e_cnt);
      chk($sformatf("vec%0d_empty", k), empty,            tbl[k].e_empty);
      tick();
    end
`ifdef INPUT_PORT_FIFO_UNDERFLOW_STICKY_EN
    // The flag set by the empty read must still hold.
    @(negedge clk);
    chk("underflow_sticky", underflow, 1);
`endif

    // Full: fill with 1..8. A 9th offer must be refused. Then drain in order.
    do_reset();
    for (int k = 1; k <= 8; k++) cyc(0, 1, 4'(k), NOP);
    drive(0, 1, 4'hF, NOP);
    chk("full_flag", full, 1);
    chk("full_rdy", pif.in_ready, 0);
    chk("full_cnt", fifo_count, 8);
    tick();
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 4'h0, RD);
      chk("full_drain", i_pins, k);
      tick();
    end
    drive(0, 0, 4'h0, NOP);
    chk("full_drained_empty", empty, 1);
    tick();

    // Simultaneous push and pop with count 3.
    do_reset();
    cyc(0, 1, 4'hA, NOP);
    cyc(0, 1, 4'hB, NOP);
    cyc(0, 1, 4'hC, NOP);
    drive(0, 1, 4'h5, RD);
    chk("pp_head", i_pins, 4'hA);
    tick();
    drive(0, 0, 4'h0, NOP);
    chk("pp_cnt", fifo_count, 3);
    chk("pp_next", i_pins, 4'hB);
    tick();
    cyc(0, 0, 4'h0, RD);
    cyc(0, 0, 4'h0, RD);
    drive(0, 0, 4'h0, RD);
    chk("pp_tail", i_pins, 4'h5);
    tick();

    // Wrap-around: push and pop each cycle with an incrementing nibble.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 4'(k), (k > 0) ? RD : NOP);
      if (k > 0) chk("wrap_order", i_pins, (k - 1) % 16);
      chk("wrap_cnt_le8", fifo_count <= 8, 1);
      tick();
    end

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      bit r, v;
      logic [7:0] i;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 99) < 55);
      i = ($urandom_range(0, 1) == 1) ? {2'b10, 3'($urandom), 3'b100} : 8'($urandom);
      cyc(r, v, 4'($urandom), i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
